// File: rtl/vga_timing_pkg.sv
// Shared types and mode constants for the VGA raster timing block.
// Default mode is 1024x768@60.
package vga_timing_pkg;
  localparam int COORD_W = 12;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_e;

  localparam int MODE_H_RES    = 1024;
  localparam int MODE_H_FP     = 24;
  localparam int MODE_H_SYNC_W = 136;
  localparam int MODE_H_BP     = 160;
  localparam int MODE_V_RES    = 768;
  localparam int MODE_V_FP     = 3;
  localparam int MODE_V_SYNC_W = 6;
  localparam int MODE_V_BP     = 29;

  localparam bit SYNC_ACTIVE_LOW = 1'b0;
endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with a park value, plus a sync
// flag registered from the next count so it lines up with the count it describes.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter coord_t TOTAL      = coord_t'(16),
  parameter coord_t PARK       = coord_t'(8),
  parameter coord_t SYNC_START = coord_t'(10),
  parameter coord_t SYNC_END   = coord_t'(13),
  parameter bit     SYNC_POL   = 1'b0
) (
  input  logic   pix_clk,
  input  logic   rst,
  input  logic   park,
  input  logic   start,
  input  logic   inc,
  output coord_t cnt,
  output logic   wrap,
  output logic   sync
);
  coord_t cnt_nxt;

  assign wrap = (cnt == TOTAL - coord_t'(1));

  always_comb begin
    cnt_nxt = cnt;
    if (park)       cnt_nxt = PARK;
    else if (start) cnt_nxt = '0;
    else if (inc)   cnt_nxt = wrap ? '0 : cnt + coord_t'(1);
  end

  // The park value always sits before the sync window, so parking deasserts sync.
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      cnt  <= PARK;
      sync <= ~SYNC_POL;
    end else begin
      cnt  <= cnt_nxt;
      sync <= (cnt_nxt >= SYNC_START && cnt_nxt < SYNC_END) ? SYNC_POL : ~SYNC_POL;
    end
  end
endmodule

// File: rtl/vga_timing_ctrl.sv
// Free-running VGA raster sequencer; starts on ENABLE and only stops at the
// end of a complete frame.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_RES    = MODE_H_RES,
  parameter int H_FP     = MODE_H_FP,
  parameter int H_SYNC_W = MODE_H_SYNC_W,
  parameter int H_BP     = MODE_H_BP,
  parameter int V_RES    = MODE_V_RES,
  parameter int V_FP     = MODE_V_FP,
  parameter int V_SYNC_W = MODE_V_SYNC_W,
  parameter int V_BP     = MODE_V_BP,
  parameter bit SYNC_POL = SYNC_ACTIVE_LOW
) (
  input  logic               PIX_CLK,
  input  logic               RST,
  input  logic               ENABLE,
  output logic [COORD_W-1:0] HORIZONTAL,
  output logic [COORD_W-1:0] VERTICAL,
  output logic               H_SYNC,
  output logic               V_SYNC,
  output logic               LINE_START,
  output logic               FRAME_START,
  output logic               BUSY
);
  localparam int H_TOTAL = H_RES + H_FP + H_SYNC_W + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC_W + V_BP;

  if (H_TOTAL > 4095 || V_TOTAL > 4095 ||
      H_RES < 1 || H_FP < 1 || H_SYNC_W < 1 || H_BP < 1 ||
      V_RES < 1 || V_FP < 1 || V_SYNC_W < 1 || V_BP < 1) begin : g_bad_mode
    $error("vga_timing_ctrl: illegal timing parameters");
  end

  state_e state;
  logic   h_wrap, v_wrap, frame_end, start, count, stop_now;

  assign frame_end = h_wrap & v_wrap;
  assign start     = (state == IDLE) & ENABLE;
  assign count     = (state != IDLE);
  assign stop_now  = (state == STOPPING) & ~ENABLE & frame_end;

  vga_axis_counter #(
    .TOTAL(coord_t'(H_TOTAL)), .PARK(coord_t'(H_RES)),
    .SYNC_START(coord_t'(H_RES + H_FP)), .SYNC_END(coord_t'(H_RES + H_FP + H_SYNC_W)),
    .SYNC_POL(SYNC_POL)
  ) u_h (
    .pix_clk(PIX_CLK), .rst(RST), .park(stop_now), .start(start), .inc(count),
    .cnt(HORIZONTAL), .wrap(h_wrap), .sync(H_SYNC)
  );

  vga_axis_counter #(
    .TOTAL(coord_t'(V_TOTAL)), .PARK(coord_t'(V_RES)),
    .SYNC_START(coord_t'(V_RES + V_FP)), .SYNC_END(coord_t'(V_RES + V_FP + V_SYNC_W)),
    .SYNC_POL(SYNC_POL)
  ) u_v (
    .pix_clk(PIX_CLK), .rst(RST), .park(stop_now), .start(start), .inc(count & h_wrap),
    .cnt(VERTICAL), .wrap(v_wrap), .sync(V_SYNC)
  );

  always_ff @(posedge PIX_CLK) begin
    if (RST) begin
      state       <= IDLE;
      BUSY        <= 1'b0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state       <= ENABLE ? RUN : IDLE;
          BUSY        <= ENABLE;
          LINE_START  <= ENABLE;
          FRAME_START <= ENABLE;
        end
        default: begin
          // The last frame completes, then the counters park with no new strobe.
          if (stop_now) begin
            state       <= IDLE;
            BUSY        <= 1'b0;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
          end else begin
            state       <= ENABLE ? RUN : STOPPING;
            BUSY        <= 1'b1;
            LINE_START  <= h_wrap;
            FRAME_START <= frame_end;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl on a 16x8 raster; a second instance
// with active-high syncs checks the idle sync level.
module tb_vga_timing_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, en2;
  logic [11:0] h, v, h2, v2;
  logic        hs, vs, ls, fs, busy;
  logic        hs2, vs2, ls2, fs2, busy2;

  vga_timing_ctrl #(
    .H_RES(8), .H_FP(2), .H_SYNC_W(3), .H_BP(3),
    .V_RES(4), .V_FP(1), .V_SYNC_W(2), .V_BP(1), .SYNC_POL(1'b0)
  ) dut (
    .PIX_CLK(clk), .RST(rst), .ENABLE(en), .HORIZONTAL(h), .VERTICAL(v),
    .H_SYNC(hs), .V_SYNC(vs), .LINE_START(ls), .FRAME_START(fs), .BUSY(busy)
  );

  vga_timing_ctrl #(
    .H_RES(8), .H_FP(2), .H_SYNC_W(3), .H_BP(3),
    .V_RES(4), .V_FP(1), .V_SYNC_W(2), .V_BP(1), .SYNC_POL(1'b1)
  ) dut_pol1 (
    .PIX_CLK(clk), .RST(rst), .ENABLE(en2), .HORIZONTAL(h2), .VERTICAL(v2),
    .H_SYNC(hs2), .V_SYNC(vs2), .LINE_START(ls2), .FRAME_START(fs2), .BUSY(busy2)
  );

  typedef struct {
    int h, v, hs, vs, ls, fs, busy;
  } exp_t;

  exp_t q[$];
  int errs = 0, checks = 0;
  int m_st = 0, mh = 8, mv = 4;  // model: 0 idle, 1 run, 2 stopping
  int cyc_n = 0, last_fs = -1, fs_count = 0, vs_run = 0, prev_vs = 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model(input logic r, input logic e);
    int fe;
    if (r) begin
      m_st = 0; mh = 8; mv = 4;
    end else if (m_st == 0) begin
      if (e) begin m_st = 1; mh = 0; mv = 0; end
    end else begin
      fe = (mh == 15 && mv == 7);
      if (m_st == 2 && !e && fe) begin
        m_st = 0; mh = 8; mv = 4;
      end else begin
        if (mh == 15) begin
          mh = 0;
          mv = (mv == 7) ? 0 : mv + 1;
        end else mh = mh + 1;
        m_st = e ? 1 : 2;
      end
    end
  endtask

  task automatic monitor();
    exp_t x;
    x = q.pop_front();
    chk("horizontal", h, x.h);
    chk("vertical", v, x.v);
    chk("h_sync", hs, x.hs);
    chk("v_sync", vs, x.vs);
    chk("line_start", ls, x.ls);
    chk("frame_start", fs, x.fs);
    chk("busy", busy, x.busy);
    if (fs === 1'b1) begin
      if (last_fs >= 0) chk("fs_period", cyc_n - last_fs, 128);
      last_fs = cyc_n;
      fs_count++;
    end
    if (busy !== 1'b1) last_fs = -1;
    if (vs === 1'b0) vs_run++;
    else begin
      if (vs_run > 0) chk("vs_len", vs_run, 32);
      vs_run = 0;
    end
    if (busy === 1'b1 && vs !== prev_vs[0]) chk("vs_edge_h", h, 0);
    prev_vs = int'(vs);
  endtask

  task automatic step(input logic r, input logic e);
    exp_t x;
    rst = r; en = e;
    model(r, e);
    x.h    = mh;
    x.v    = mv;
    x.hs   = (mh >= 10 && mh < 13) ? 0 : 1;
    x.vs   = (mv >= 5 && mv < 7) ? 0 : 1;
    x.ls   = (m_st != 0 && mh == 0) ? 1 : 0;
    x.fs   = (m_st != 0 && mh == 0 && mv == 0) ? 1 : 0;
    x.busy = (m_st != 0) ? 1 : 0;
    q.push_back(x);
    @(posedge clk);
    #1;
    cyc_n++;
    monitor();
  endtask

  task automatic run_to(input int th, input int tv, input logic e);
    for (int i = 0; i < 300 && !(mh == th && mv == tv); i++) step(1'b0, e);
    chk("reach_pos", (mh == th && mv == tv) ? 1 : 0, 1);
  endtask

  initial begin
    int n, snap;
    rst = 1'b1; en = 1'b0; en2 = 1'b0;
    // reset
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("pol1_hs", hs2, 0);
    chk("pol1_vs", vs2, 0);
    chk("pol1_h", h2, 8);
    chk("pol1_busy", busy2, 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    // start and continuous run over two full frames
    step(1'b0, 1'b1);
    chk("start_fs", fs, 1);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1);
    chk("frames_seen", fs_count, 3);
    // stop at (3,2): finish the frame then park
    run_to(3, 2, 1'b1);
    snap = fs_count;
    n = 0;
    for (int i = 0; i < 300 && m_st != 0; i++) begin
      step(1'b0, 1'b0);
      n++;
    end
    chk("stop_len", n, 93);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0);
    chk("stop_no_fs", fs_count - snap, 0);
    chk("stop_busy", busy, 0);
    // re-enable before the frame ends: no gap in the raster
    step(1'b0, 1'b1);
    run_to(3, 2, 1'b1);
    run_to(6, 5, 1'b0);
    snap = fs_count;
    for (int i = 0; i < 300 && fs_count == snap; i++) step(1'b0, 1'b1);
    chk("reen_fs_seen", fs_count - snap, 1);
    // mid-frame reset, reset with enable held, then release
    run_to(5, 3, 1'b1);
    step(1'b1, 1'b1);
    chk("midrst_h", h, 8);
    step(1'b1, 1'b1);
    chk("rst_en_busy", busy, 0);
    step(1'b0, 1'b1);
    chk("rel_fs", fs, 1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    chk("pol1_end_vs", vs2, 0);
    chk("pol1_end_busy", busy2, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Free-running VGA timing controller that sequences the pixel-position datapath. It generates the HORIZONTAL/VERTICAL raster counters consumed by the display-enable checker, plus H_SYNC/V_SYNC and line/frame strobes, all on PIX_CLK. Start and stop requests are accepted at any time, but the raster only stops at a frame boundary, so the monitor never sees a truncated frame.

## Interface
- H_RES, 1024, active pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC_W, 136, horizontal sync width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_RES, 768, active lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC_W, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high), applies to both syncs
- PIX_CLK  in  1  pixel clock; the only clock
- RST  in  1  synchronous, active-high reset
- ENABLE  in  1  level request to run the raster
- HORIZONTAL  out  12  pixel counter
- VERTICAL  out  12  line counter
- H_SYNC  out  1  horizontal sync
- V_SYNC  out  1  vertical sync
- LINE_START  out  1  one-cycle strobe, HORIZONTAL == 0 while running
- FRAME_START  out  1  one-cycle strobe, HORIZONTAL == 0 and VERTICAL == 0 while running
- BUSY  out  1  state != IDLE

## Operation
- H_TOTAL = H_RES+H_FP+H_SYNC_W+H_BP; V_TOTAL likewise. Both must be ≤ 4095, and every parameter must be ≥ 1; otherwise elaboration fails.
- The block has three states: IDLE, RUN and STOPPING.
- IDLE:
  - HORIZONTAL = H_RES and VERTICAL = V_RES. This parks the raster in blanking, so the downstream checker deasserts display enable.
  - Syncs are inactive (= ~SYNC_POL) and strobes are 0.
  - ENABLE=1 moves to RUN.
- RUN:
  - HORIZONTAL increments every cycle.
  - At H_TOTAL-1, HORIZONTAL wraps to 0 and VERTICAL increments.
  - At (H_TOTAL-1, V_TOTAL-1), both counters wrap to 0.
  - ENABLE=0 moves to STOPPING.
- STOPPING:
  - Counting is identical to RUN.
  - ENABLE=1 returns to RUN with no disturbance to the counters.
  - At (H_TOTAL-1, V_TOTAL-1) with ENABLE=0, the next cycle is IDLE with parked counters. No FRAME_START is issued.
- Sync windows:
  - H_SYNC is active iff H_RES+H_FP ≤ HORIZONTAL < H_RES+H_FP+H_SYNC_W.
  - V_SYNC is active iff V_RES+V_FP ≤ VERTICAL < V_RES+V_FP+V_SYNC_W, for whole lines.
  - Syncs are inactive in IDLE.
- All arithmetic is unsigned 12-bit. Comparisons use parameters pre-computed as 12-bit constants, and no counter ever exceeds TOTAL-1.

## Timing
- All outputs are registered.
- Reset values: HORIZONTAL=H_RES, VERTICAL=V_RES, H_SYNC=V_SYNC=~SYNC_POL, LINE_START=FRAME_START=0, BUSY=0, state IDLE.
- RST takes priority over ENABLE in the same cycle. RST mid-frame yields the reset values on the next edge.
- Start latency: ENABLE sampled high in IDLE at edge k gives HORIZONTAL=0, VERTICAL=0, FRAME_START=1, LINE_START=1, BUSY=1 after edge k.
- H_SYNC, V_SYNC and the strobes are cycle-aligned with the counter values they describe, so no extra pipeline offset is needed downstream.
- FRAME_START period is exactly H_TOTAL·V_TOTAL cycles while running. The LINE_START period is H_TOTAL.
- BUSY falls in the same cycle that the counters park.

## Structure
- Shared package vga_timing_pkg holds:
  - COORD_W = 12
  - the state enum (IDLE/RUN/STOPPING)
  - the 1024x768@60 mode constants
  - a SYNC_ACTIVE_LOW constant
- Natural sub-module: vga_axis_counter, instantiated twice (horizontal and vertical). It contains:
  - a counter with increment-enable, wrap at TOTAL-1 and park value
  - a wrap output
  - the registered sync-window compare
- The FSM and strobe logic live in vga_timing_ctrl.

## Test plan
Bench parameters: H_RES=8, H_FP=2, H_SYNC_W=3, H_BP=3 (H_TOTAL=16); V_RES=4, V_FP=1, V_SYNC_W=2, V_BP=1 (V_TOTAL=8); SYNC_POL=0.
- Reset: RST high 2 cycles → H=8, V=4, H_SYNC=V_SYNC=1, BUSY=0, strobes 0. Repeat with SYNC_POL=1 → syncs idle at 0.
- Start: ENABLE rises at edge k → after k: H=0, V=0, FRAME_START=1. Then:
  - H_SYNC=0 exactly for H=10..12.
  - H=15 is followed by H=0, V=1, LINE_START=1.
- Frame: continuous run → FRAME_START every 128 cycles. V_SYNC=0 for exactly V=5..6, i.e. 32 consecutive cycles, changing only at H=0.
- Stop: ENABLE falls at H=3, V=2 → counting continues to (15,7), then H=8, V=4, BUSY=0. No FRAME_START and no further sync pulses.
- Re-enable: ENABLE low at (3,2), high again at (6,5) → no gap; next FRAME_START 128 cycles after the previous one.
- Mid-frame reset: RST at (5,3) → reset values next cycle. RST and ENABLE both high → stays IDLE; RST low with ENABLE high → (0,0) and FRAME_START on the following edge.
